// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues one outstanding request at a time to a variable-latency instruction memory.
//
//   state   | meaning
//   --------+----------------------------------------------
//   S_FETCH | no request outstanding, strobe imem_req
//   S_WAIT  | request outstanding, waiting for imem_valid
//   S_HOLD  | response buffered, IF/ID blocked by a stall
//   S_DROP  | outstanding response must be discarded
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_write,
   input  logic        IF_ID_Write,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_inst,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_inst_q, if_id_inst_d;
   logic        if_id_valid_q, if_id_valid_d;

   logic        accept;
   logic        deliver;
   logic [31:0] deliver_inst;
   logic [31:0] target;
   logic [31:0] pc_inc;

   assign accept = PC_write && IF_ID_Write;
   assign target = {flush_target[31:2], 2'b00};
   assign pc_inc = pc_q + 32'd4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_d        = buf_q;
      deliver      = 1'b0;
      deliver_inst = imem_rdata;

      case (state_q)
         S_FETCH: begin
            if (flush) pc_d = target;
            else       state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush) begin
               pc_d    = target;
               state_d = imem_valid ? S_FETCH : S_DROP;
            end else if (imem_valid && accept) begin
               deliver      = 1'b1;
               deliver_inst = imem_rdata;
               pc_d         = pc_inc;
               state_d      = S_FETCH;
            end else if (imem_valid) begin
               buf_d   = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (flush) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (accept) begin
               deliver      = 1'b1;
               deliver_inst = buf_q;
               pc_d         = pc_inc;
               state_d      = S_FETCH;
            end
         end
         S_DROP: begin
            // the late response is the only thing that can release DROP,
            // even if it coincides with another redirect
            if (flush)      pc_d = target;
            if (imem_valid) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
      if (flush) begin
         if_id_inst_d  = NOP_INST;
         if_id_valid_d = 1'b0;
      end else if (IF_ID_Write) begin
         if (deliver) begin
            if_id_pc_d    = pc_q;
            if_id_inst_d  = deliver_inst;
            if_id_valid_d = 1'b1;
         end else begin
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         buf_q         <= '0;
         if_id_pc_q    <= '0;
         if_id_inst_q  <= NOP_INST;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         buf_q         <= buf_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   assign imem_req    = (state_q == S_FETCH) && !flush;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_inst  = if_id_inst_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stalls/flushes/latency
// checked against a transaction-level model of the fetch unit and memory.
`timescale 1ns/1ps
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, PC_write, IF_ID_Write, flush, imem_valid;
   logic [31:0] flush_target, imem_rdata;
   logic        imem_req, if_id_valid, imem_req2, if_id_valid2;
   logic [31:0] imem_addr, pc, if_id_pc, if_id_inst;
   logic [31:0] imem_addr2, pc2, if_id_pc2, if_id_inst2;

   int total = 0;
   int bad   = 0;

   // model: fetch unit as "outstanding / discard / buffered" flags
   logic [31:0] m_pc, m_buf, m_ifpc, m_ifinst;
   bit          m_ifv, m_out, m_disc, m_hb;
   // memory: single pending response with a latency counter
   bit          mem_pend;
   int          mem_cnt;
   int          mem_lat;
   logic [31:0] mem_addr;

   fetch_stage dut (
      .clk(clk), .reset(reset), .PC_write(PC_write), .IF_ID_Write(IF_ID_Write),
      .flush(flush), .flush_target(flush_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .pc(pc), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .PC_write(PC_write), .IF_ID_Write(IF_ID_Write),
      .flush(flush), .flush_target(flush_target), .imem_req(imem_req2),
      .imem_addr(imem_addr2), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .pc(pc2), .if_id_pc(if_id_pc2), .if_id_inst(if_id_inst2), .if_id_valid(if_id_valid2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0003;
   endfunction

   // drive inputs for the current cycle; memory response comes from the memory model
   task automatic drive(input bit pw, input bit iw, input bit fl, input logic [31:0] tgt);
      PC_write     = pw;
      IF_ID_Write  = iw;
      flush        = fl;
      flush_target = tgt;
      imem_valid   = mem_pend && (mem_cnt == 0);
      imem_rdata   = imem_valid ? inst_of(mem_addr) : $urandom;
      #1;
   endtask

   // apply the current inputs to the model, then move to the next cycle
   task automatic advance();
      logic [31:0] pc0, tgt, di;
      bit acc, req, dlv;
      pc0 = m_pc;
      tgt = {flush_target[31:2], 2'b00};
      acc = PC_write && IF_ID_Write;
      req = !m_out && !m_hb && !flush;
      dlv = 0;
      di  = '0;
      if (reset) begin
         m_pc = 32'h0; m_out = 0; m_disc = 0; m_hb = 0; m_buf = '0;
         m_ifpc = 32'h0; m_ifinst = NOP; m_ifv = 0; mem_pend = 0; mem_cnt = 0;
      end else begin
         if (m_hb) begin
            if (flush) begin m_hb = 0; m_pc = tgt; end
            else if (acc) begin dlv = 1; di = m_buf; m_hb = 0; m_pc = pc0 + 32'd4; end
         end else if (m_out) begin
            if (imem_valid) begin
               m_out = 0;
               if (!flush && !m_disc) begin
                  if (acc) begin dlv = 1; di = imem_rdata; m_pc = pc0 + 32'd4; end
                  else begin m_hb = 1; m_buf = imem_rdata; end
               end
            end else if (flush) m_disc = 1;
            if (flush) m_pc = tgt;
         end else if (flush) m_pc = tgt;
         else if (req) begin m_out = 1; m_disc = 0; end

         if (flush) begin m_ifv = 0; m_ifinst = NOP; end
         else if (IF_ID_Write) begin
            if (dlv) begin m_ifpc = pc0; m_ifinst = di; m_ifv = 1; end
            else begin m_ifv = 0; m_ifinst = NOP; end
         end

         if (imem_valid) mem_pend = 0;
         else if (mem_pend && mem_cnt > 0) mem_cnt--;
         if (req) begin mem_pend = 1; mem_cnt = mem_lat - 1; mem_addr = pc0; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      mem_lat = 1;
      drive(1, 1, 0, 0);
      advance();
      drive(1, 1, 0, 0);
      advance();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(1, 1, 0, 0);
      total += 6;
      if (pc !== 32'h0)          begin bad++; $display("FAIL reset_pc got %h want 0", pc); end
      if (if_id_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
      if (if_id_inst !== NOP)    begin bad++; $display("FAIL reset_inst got %h want %h", if_id_inst, NOP); end
      if (if_id_pc !== 32'h0)    begin bad++; $display("FAIL reset_ifpc got %h want 0", if_id_pc); end
      if (imem_req !== 1'b1)     begin bad++; $display("FAIL reset_req got %b want 1", imem_req); end
      if (pc2 !== 32'hFFFF_FFFC || imem_req2 !== 1'b1)
         begin bad++; $display("FAIL reset_pc2 got %h/%b want fffffffc/1", pc2, imem_req2); end
   endtask

   task automatic test_basic();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 0);
         total += 2;
         if (k < 3 && (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)))
            begin bad++; $display("FAIL basic_req k=%0d got %b/%h want 1/%h", k, imem_req, imem_addr, 4 * k); end
         if (k > 0 && (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (k - 1)) || if_id_inst !== inst_of(32'(4 * (k - 1)))))
            begin bad++; $display("FAIL basic_ifid k=%0d got %b/%h/%h want 1/%h", k, if_id_valid, if_id_pc, if_id_inst, 4 * (k - 1)); end
         if (k == 3) break;
         advance();
         drive(1, 1, 0, 0);
         total += 2;
         if (imem_req !== 1'b0) begin bad++; $display("FAIL basic_noreq k=%0d got %b want 0", k, imem_req); end
         if (if_id_valid !== 1'b0) begin bad++; $display("FAIL basic_bubble k=%0d got %b want 0", k, if_id_valid); end
         advance();
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(1, 1, 0, 0); advance();
      drive(1, 1, 0, 0); advance();
      drive(1, 1, 0, 0); advance();
      for (int c = 0; c < 3; c++) begin
         drive(0, 0, 0, 0);
         if (c > 0) begin
            total += 3;
            if (pc !== 32'h4)        begin bad++; $display("FAIL stall_pc c=%0d got %h want 4", c, pc); end
            if (imem_req !== 1'b0)   begin bad++; $display("FAIL stall_req c=%0d got %b want 0", c, imem_req); end
            if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0)
               begin bad++; $display("FAIL stall_ifid c=%0d got %b/%h want 0/0", c, if_id_valid, if_id_pc); end
         end
         advance();
      end
      drive(1, 1, 0, 0); advance();
      drive(1, 1, 0, 0);
      total += 3;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_inst !== inst_of(32'h4))
         begin bad++; $display("FAIL release_ifid got %b/%h/%h want 1/4/%h", if_id_valid, if_id_pc, if_id_inst, inst_of(32'h4)); end
      if (pc !== 32'h8) begin bad++; $display("FAIL release_pc got %h want 8", pc); end
      if (imem_req !== 1'b1 || imem_addr !== 32'h8)
         begin bad++; $display("FAIL release_req got %b/%h want 1/8", imem_req, imem_addr); end
   endtask

   task automatic test_latency();
      do_reset();
      mem_lat = 4;
      drive(1, 1, 0, 0); advance();
      for (int c = 1; c <= 4; c++) begin
         drive(1, 1, 0, 0);
         total += 2;
         if (imem_req !== 1'b0)    begin bad++; $display("FAIL lat_req c=%0d got %b want 0", c, imem_req); end
         if (if_id_valid !== 1'b0) begin bad++; $display("FAIL lat_bubble c=%0d got %b want 0", c, if_id_valid); end
         advance();
      end
      drive(1, 1, 0, 0);
      total++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_inst !== inst_of(32'h0))
         begin bad++; $display("FAIL lat_ifid got %b/%h/%h want 1/0/%h", if_id_valid, if_id_pc, if_id_inst, inst_of(32'h0)); end
   endtask

   task automatic test_flush_wait();
      bit seen;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 0); advance();
         drive(1, 1, 0, 0); advance();
      end
      mem_lat = 3;
      drive(1, 1, 0, 0);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10)
         begin bad++; $display("FAIL fw_req got %b/%h want 1/10", imem_req, imem_addr); end
      advance();
      drive(1, 1, 1, 32'h41);
      advance();
      drive(1, 1, 0, 0);
      total += 2;
      if (pc !== 32'h40) begin bad++; $display("FAIL fw_pc got %h want 40", pc); end
      if (imem_req !== 1'b0 || if_id_valid !== 1'b0)
         begin bad++; $display("FAIL fw_drop got req=%b valid=%b want 0/0", imem_req, if_id_valid); end
      seen = 0;
      for (int n = 0; n < 8 && !seen; n++) begin
         if (imem_req === 1'b1) seen = 1;
         else begin
            total++;
            if (if_id_valid !== 1'b0) begin bad++; $display("FAIL fw_discard got %b want 0", if_id_valid); end
            advance();
            drive(1, 1, 0, 0);
         end
      end
      total += 2;
      if (!seen) begin bad++; $display("FAIL fw_timeout got no req want req"); end
      if (imem_addr !== 32'h40 || pc !== 32'h40)
         begin bad++; $display("FAIL fw_target got %h/%h want 40/40", imem_addr, pc); end
      mem_lat = 1;
      advance();
      drive(1, 1, 0, 0); advance();
      drive(1, 1, 0, 0);
      total++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_inst !== inst_of(32'h40))
         begin bad++; $display("FAIL fw_ifid got %b/%h/%h want 1/40/%h", if_id_valid, if_id_pc, if_id_inst, inst_of(32'h40)); end
   endtask

   task automatic test_flush_valid();
      do_reset();
      drive(1, 1, 0, 0); advance();
      drive(1, 0, 1, 32'h83);
      total++;
      if (imem_valid !== 1'b1) begin bad++; $display("FAIL fv_setup got valid=%b want 1", imem_valid); end
      advance();
      drive(1, 1, 0, 0);
      total += 3;
      if (if_id_valid !== 1'b0 || if_id_inst !== NOP)
         begin bad++; $display("FAIL fv_bubble got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
      if (pc !== 32'h80) begin bad++; $display("FAIL fv_pc got %h want 80", pc); end
      if (imem_req !== 1'b1 || imem_addr !== 32'h80)
         begin bad++; $display("FAIL fv_req got %b/%h want 1/80", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(1, 1, 0, 0); advance();
      drive(1, 1, 0, 0); advance();
      drive(1, 1, 0, 0);
      total += 2;
      if (pc2 !== 32'h0 || imem_addr2 !== 32'h0)
         begin bad++; $display("FAIL wrap_pc got %h/%h want 0/0", pc2, imem_addr2); end
      if (if_id_valid2 !== 1'b1 || if_id_pc2 !== 32'hFFFF_FFFC || if_id_inst2 !== inst_of(32'h0))
         begin bad++; $display("FAIL wrap_ifid got %b/%h/%h want 1/fffffffc/%h", if_id_valid2, if_id_pc2, if_id_inst2, inst_of(32'h0)); end
   endtask

   task automatic test_random();
      bit exp_req;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) == 0, $urandom);
         mem_lat = $urandom_range(1, 4);
         exp_req = !m_out && !m_hb && !flush;
         total += 4;
         if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d got %h want %h", c, pc, m_pc); end
         if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc))
            begin bad++; $display("FAIL rnd_req c=%0d got %b/%h want %b/%h", c, imem_req, imem_addr, exp_req, m_pc); end
         if (if_id_valid !== m_ifv || if_id_inst !== m_ifinst)
            begin bad++; $display("FAIL rnd_ifid c=%0d got %b/%h want %b/%h", c, if_id_valid, if_id_inst, m_ifv, m_ifinst); end
         if (if_id_pc !== m_ifpc)
            begin bad++; $display("FAIL rnd_ifpc c=%0d got %h want %h", c, if_id_pc, m_ifpc); end
         advance();
      end
   endtask

   initial begin
      reset = 1'b1; PC_write = 1'b1; IF_ID_Write = 1'b1; flush = 1'b0;
      flush_target = '0; imem_valid = 1'b0; imem_rdata = '0;
      mem_pend = 0; mem_cnt = 0; mem_lat = 1; mem_addr = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_stall();
      test_latency();
      test_flush_wait();
      test_flush_valid();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
